// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   funct3_e : access size/sign encodings carried on req_funct3
//   state_e  : control FSM states (IDLE -> ACCESS -> RESP)
//   MEM_WORDS_DEFAULT : default data memory depth in 32-bit words
package lsu_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 1024;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response channel of the load/store unit.
//   req_*  : valid/ready request (we, funct3, byte address, right-aligned store data)
//   resp_* : valid/ready response (extended load data, error flag)
// master = core side, slave = load/store unit side.
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   funct3     : access size/sign
//   offset     : byte address bits [1:0]
//   store_data : right-aligned store data
//   load_word  : raw 32-bit word read from memory
//   mask       : byte-lane write enables for a store
//   lane_wdata : store data replicated across lanes
//   load_data  : selected lane, sign- or zero-extended to 32 bits
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  mask,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    // Bring the addressed lane down to bit 0 so every size extends from the bottom.
    assign shifted = load_word >> {offset, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        mask       = 4'b0000;
        lane_wdata = 32'h0000_0000;
        load_data  = 32'h0000_0000;
        case (funct3)
            F3_B: begin
                mask       = 4'b0001 << offset;
                lane_wdata = {4{store_data[7:0]}};
                load_data  = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_BU: begin
                mask       = 4'b0001 << offset;
                lane_wdata = {4{store_data[7:0]}};
                load_data  = {24'h00_0000, shifted[7:0]};
            end
            F3_H: begin
                mask       = 4'b0011 << offset;
                lane_wdata = {2{store_data[15:0]}};
                load_data  = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_HU: begin
                mask       = 4'b0011 << offset;
                lane_wdata = {2{store_data[15:0]}};
                load_data  = {16'h0000, shifted[15:0]};
            end
            F3_W: begin
                mask       = 4'b1111;
                lane_wdata = store_data;
                load_data  = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access at a time from the core, performs a
// single-cycle access to an asynchronous-read data memory and returns a response.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : core request/response channel
//   mem_cs        : memory chip select, active-low (low only in ACCESS)
//   mem_wr        : 0 = write, 1 = read
//   mem_mask      : byte-lane write enables (0 on loads)
//   mem_addr      : word index, latched byte address [31:2]
//   mem_wdata     : lane-replicated store data (0 on loads)
//   mem_rdata     : asynchronous read data
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    lsu_if.slave        bus,
    output logic        mem_cs,
    output logic        mem_wr,
    output logic [3:0]  mem_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        req_legal;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    // Legality of the incoming request; illegal ones skip memory entirely.
    always_comb begin
        req_legal = 1'b1;
        case (bus.req_funct3)
            F3_B:    ;
            F3_H:    if (bus.req_addr[0]) req_legal = 1'b0;
            F3_W:    if (bus.req_addr[1:0] != 2'b00) req_legal = 1'b0;
            F3_BU:   if (bus.req_we) req_legal = 1'b0;
            F3_HU:   if (bus.req_we || bus.req_addr[0]) req_legal = 1'b0;
            default: req_legal = 1'b0;
        endcase
        if ({2'b00, bus.req_addr[31:2]} >= MEM_WORDS) req_legal = 1'b0;
    end

    assign bus.req_ready  = (state_q == ST_IDLE) && !rst;
    assign accept         = bus.req_ready && bus.req_valid;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign mem_addr       = {2'b00, addr_q[31:2]};

    lsu_align u_align (
        .funct3     (funct3_q),
        .offset     (addr_q[1:0]),
        .store_data (wdata_q),
        .load_word  (mem_rdata),
        .mask       (lane_mask),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    always_comb begin
        state_d   = state_q;
        mem_cs    = 1'b1;
        mem_wr    = 1'b1;
        mem_mask  = 4'b0000;
        mem_wdata = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) state_d = req_legal ? ST_ACCESS : ST_RESP;
            end
            ST_ACCESS: begin
                mem_cs  = 1'b0;
                mem_wr  = ~we_q;
                if (we_q) begin
                    mem_mask  = lane_mask;
                    mem_wdata = lane_wdata;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                err_q   <= ~req_legal;
                rdata_q <= 32'h0000_0000;
            end else if (state_q == ST_ACCESS) begin
                rdata_q <= we_q ? 32'h0000_0000 : load_data;
            end
        end
    end

    // NOTE: request payload is not reset; it is only observed after an accept reloads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural memory (write on falling
// edge, asynchronous read), vector table with scoreboard, plus hand sequences
// for back-pressure, throughput and reset during ACCESS.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned MEM_WORDS = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_if bus();

    logic        mem_cs;
    logic        mem_wr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_cs    (mem_cs),
        .mem_wr    (mem_wr),
        .mem_mask  (mem_mask),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory model and access monitor.
    logic [31:0] mem [0:MEM_WORDS-1] = '{default: 32'h0};
    int          cs_count = 0;
    logic [3:0]  cap_mask;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        cap_wr;
    int          cycle = 0;
    int          accept_log[$];

    assign mem_rdata = (mem_addr < MEM_WORDS) ? mem[mem_addr[9:0]] : 32'h0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready) accept_log.push_back(cycle);
        if (mem_cs === 1'b0) begin
            cs_count  <= cs_count + 1;
            cap_mask  <= mem_mask;
            cap_addr  <= mem_addr;
            cap_wdata <= mem_wdata;
            cap_wr    <= mem_wr;
            if (!mem_wr && mem_addr < MEM_WORDS) begin
                for (int b = 0; b < 4; b++)
                    if (mem_mask[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    vec_t  vecs[$];
    resp_t sb[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input logic [3:0] exp_mask,
                                input logic [31:0] exp_wdata);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        v.exp_mask = exp_mask; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    // Present a request and wait (bounded) for its acceptance edge; leaves time at edge+1.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output bit ok);
        ok = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (bus.req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit    ok;
        bit    got;
        int    lat;
        int    cs0;
        resp_t r;
        cs0 = cs_count;
        bus.resp_ready = 1'b1;
        issue(v.we, v.f3, v.addr, v.wdata, ok);
        if (!ok) begin
            fail_now($sformatf("vec%0d_accept", idx));
            return;
        end
        sb.push_back('{v.exp_rdata, v.exp_err});
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (bus.resp_valid) got = 1'b1;
            else begin
                lat++;
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            fail_now($sformatf("vec%0d_resp", idx));
            return;
        end
        r = sb.pop_front();
        check($sformatf("vec%0d_rdata", idx), bus.resp_rdata, r.rdata);
        check($sformatf("vec%0d_err", idx), {31'b0, bus.resp_err}, {31'b0, r.err});
        check($sformatf("vec%0d_latency", idx), lat, v.exp_err ? 0 : 1);
        @(posedge clk); #1;
        check($sformatf("vec%0d_mem_accesses", idx), cs_count - cs0, v.exp_err ? 0 : 1);
        if (!v.exp_err) begin
            check($sformatf("vec%0d_mask", idx), {28'b0, cap_mask}, {28'b0, v.exp_mask});
            check($sformatf("vec%0d_wdata", idx), cap_wdata, v.exp_wdata);
            check($sformatf("vec%0d_addr", idx), cap_addr, v.addr >> 2);
            check($sformatf("vec%0d_wr", idx), {31'b0, cap_wr}, {31'b0, ~v.we});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit got;
        int cs0;
        int n0;
        int cnt;

        vecs.push_back(mk(1, F3_W,  32'h10,  32'hDEAD_BEEF, 32'h0,         0, 4'hF, 32'hDEAD_BEEF));
        vecs.push_back(mk(1, F3_B,  32'h13,  32'h0000_00A5, 32'h0,         0, 4'h8, 32'hA5A5_A5A5));
        vecs.push_back(mk(0, F3_W,  32'h10,  32'h0,         32'hA5AD_BEEF, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_B,  32'h13,  32'h0,         32'hFFFF_FFA5, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_BU, 32'h13,  32'h0,         32'h0000_00A5, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_H,  32'h12,  32'h0,         32'hFFFF_A5AD, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_HU, 32'h12,  32'h0,         32'h0000_A5AD, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_B,  32'h10,  32'h0,         32'hFFFF_FFEF, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_BU, 32'h11,  32'h0,         32'h0000_00BE, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_H,  32'h10,  32'h0,         32'hFFFF_BEEF, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_W,  32'h12,  32'h0,         32'h0,         1, 4'h0, 32'h0));
        vecs.push_back(mk(1, F3_W,  32'h1000, 32'h1234_5678, 32'h0,        1, 4'h0, 32'h0));
        vecs.push_back(mk(1, F3_H,  32'h21,  32'h1234,      32'h0,         1, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b011, 32'h10, 32'h0,         32'h0,         1, 4'h0, 32'h0));
        vecs.push_back(mk(1, F3_BU, 32'h10,  32'h55,        32'h0,         1, 4'h0, 32'h0));
        vecs.push_back(mk(0, 3'b110, 32'h10, 32'h0,         32'h0,         1, 4'h0, 32'h0));
        vecs.push_back(mk(1, F3_H,  32'h22,  32'h1234_8001, 32'h0,         0, 4'hC, 32'h8001_8001));
        vecs.push_back(mk(0, F3_H,  32'h22,  32'h0,         32'hFFFF_8001, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_HU, 32'h22,  32'h0,         32'h0000_8001, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_W,  32'h20,  32'h0,         32'h8001_0000, 0, 4'h0, 32'h0));
        vecs.push_back(mk(1, F3_W,  32'hFFC, 32'h0BAD_F00D, 32'h0,         0, 4'hF, 32'h0BAD_F00D));
        vecs.push_back(mk(0, F3_W,  32'hFFC, 32'h0,         32'h0BAD_F00D, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_B,  32'hFFF, 32'h0,         32'h0000_000B, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_W,  32'h8000_0010, 32'h0,   32'h0,         1, 4'h0, 32'h0));
        vecs.push_back(mk(1, F3_B,  32'h21,  32'hFFFF_FF7E, 32'h0,         0, 4'h2, 32'h7E7E_7E7E));
        vecs.push_back(mk(0, F3_W,  32'h20,  32'h0,         32'h8001_7E00, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_H,  32'h20,  32'h0,         32'h0000_7E00, 0, 4'h0, 32'h0));
        vecs.push_back(mk(0, F3_HU, 32'h23,  32'h0,         32'h0,         1, 4'h0, 32'h0));

        // Reset state.
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",  {31'b0, bus.req_ready},  32'h0);
        check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        check("rst_resp_rdata", bus.resp_rdata,          32'h0);
        check("rst_resp_err",   {31'b0, bus.resp_err},   32'h0);
        check("rst_mem_cs",     {31'b0, mem_cs},         32'h1);
        check("rst_mem_wr",     {31'b0, mem_wr},         32'h1);
        check("rst_mem_mask",   {28'b0, mem_mask},       32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_req_ready", {31'b0, bus.req_ready}, 32'h1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-pressure: response held for 5 cycles while a second request waits.
        bus.resp_ready = 1'b0;
        issue(0, F3_W, 32'h10, 32'h0, ok);
        if (!ok) fail_now("stall_accept");
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (bus.resp_valid) got = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!got) fail_now("stall_resp");
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h20;
        cs0 = cs_count;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall%0d_resp_valid", k), {31'b0, bus.resp_valid}, 32'h1);
            check($sformatf("stall%0d_resp_rdata", k), bus.resp_rdata, 32'hA5AD_BEEF);
            check($sformatf("stall%0d_req_ready", k), {31'b0, bus.req_ready}, 32'h0);
            @(posedge clk); #1;
        end
        check("stall_no_access", cs_count - cs0, 0);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_valid", {31'b0, bus.resp_valid}, 32'h0);
        check("stall_release_ready", {31'b0, bus.req_ready},  32'h1);

        // Throughput: req_valid and resp_ready held high.
        n0 = accept_log.size();
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h10;
        repeat (7) @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cnt = accept_log.size() - n0;
        check("thru_accepts", cnt, 3);
        if (cnt >= 3) begin
            check("thru_gap0", accept_log[n0+1] - accept_log[n0],   3);
            check("thru_gap1", accept_log[n0+2] - accept_log[n0+1], 3);
        end

        // Reset during a load ACCESS aborts without a response.
        issue(0, F3_W, 32'h10, 32'h0, ok);
        if (!ok) fail_now("rstld_accept");
        check("rstld_in_access", {31'b0, mem_cs}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstld_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        check("rstld_mem_cs",     {31'b0, mem_cs},         32'h1);
        check("rstld_req_ready",  {31'b0, bus.req_ready},  32'h0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("rstld_idle%0d_valid", k), {31'b0, bus.resp_valid}, 32'h0);
        end
        check("rstld_req_ready_after", {31'b0, bus.req_ready}, 32'h1);

        // Reset during a store ACCESS: the falling-edge write still lands.
        issue(1, F3_W, 32'h30, 32'h5555_AAAA, ok);
        if (!ok) fail_now("rstst_accept");
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstst_resp_valid", {31'b0, bus.resp_valid}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec(mk(0, F3_W, 32'h30, 32'h0, 32'h5555_AAAA, 0, 4'h0, 32'h0), 100);

        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
